key_command_conditioner: RTL
============================

Name: key_command_conditioner

Overview:
- Sits directly upstream of the SDRAM read/write Avalon master on the DE1-SoC lab4 system.
- Converts the four raw, active-low, bouncing KEY pushbuttons into the clean control inputs the master consumes: inc_addr, dec_addr, read, write.
- Per key: synchronises, debounces, and generates either a one-shot pulse (read/write) or a held level with auto-repeat edges (inc/dec). Holding an address key steps the address repeatedly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz).
- REPEAT_EN, 1, 1 = auto-repeat enabled on inc/dec; 0 = single step per press.
- REPEAT_DELAY, 25000000, cycles a key is held before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 5000000, auto-repeat period in cycles; must be even and >=2.
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- key_n, input, 4, raw KEY pins, 0 = pressed; [3]=inc, [2]=dec, [1]=read, [0]=write.
- inc_addr, output, 1, address-increment level with repeat edges.
- dec_addr, output, 1, address-decrement level with repeat edges.
- read, output, 1, one-cycle read request pulse.
- write, output, 1, one-cycle write request pulse.
- key_pressed, output, 4, debounced pressed state (1 = pressed), debug.

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low; every register is cleared on assertion, independent of clk.
- Reset values:
  - Synchroniser flops and debounced-stable registers: 1 (released).
  - All counters: 0.
  - Repeat FSMs: R_IDLE.
  - All outputs: 0.
- Reset mid-press or mid-repeat: outputs drop to 0 immediately. After release of reset, a key still held is re-accepted only after the full debounce time.
- Synchroniser: 2 flops per key. No combinational path from key_n to any output.
- Debounce, per key:
  - If sync != stable, the counter increments; otherwise it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != stable: stable <= sync and counter <= 0.
  - Any glitch back to the stable value restarts the count.
  - key_pressed = ~stable.
- Press latency: the first output change occurs DEBOUNCE_CYCLES+3 cycles after key_n settles (2 sync + debounce + 1 output register). Release latency is the same.
- Pulse outputs (read, write):
  - Registered one-cycle pulse on the rising edge of key_pressed[1] / key_pressed[0].
  - Holding the key produces no further pulses.
  - If both edges occur in the same cycle, read pulses and write is dropped.
- Repeat FSM, one per inc/dec channel:
  - States: R_IDLE, R_HOLD, R_LO, R_HI.
  - Output is 1 in R_HOLD and R_HI.
  - R_IDLE -> R_HOLD on the pressed rising edge; counter cleared.
  - R_HOLD -> R_LO when the counter reaches REPEAT_DELAY-1, only if REPEAT_EN=1; otherwise stay in R_HOLD.
  - R_LO -> R_HI and R_HI -> R_LO each after REPEAT_PERIOD/2 cycles. Each R_LO->R_HI transition gives the master one fresh rising edge.
  - From any state, release -> R_IDLE; output 0 on the next cycle.
- Inc/dec priority:
  - While key_pressed[3] is 1, the dec FSM is held in R_IDLE and dec_addr = 0. Inc wins.
  - When inc is released, dec starts fresh only on a new dec press edge. A dec key still held does not resume.
- Counter behaviour: counters saturate, never wrap. The R_HOLD counter stops at REPEAT_DELAY-1 when REPEAT_EN=0.
- Outputs are all registered. read, write and the repeat outputs are independent, so read and inc_addr may be high simultaneously.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1):
- Clean read press: key_n=4'b1101 held 30 cycles -> read = 1 for exactly one cycle, 7 cycles after the falling edge. write, inc_addr and dec_addr stay 0. key_pressed[1] = 1 until 7 cycles after release.
- Bounce rejection: key_n[0] toggles every 2 cycles for 20 cycles, then returns to 1 -> write never pulses and key_pressed stays 0. Then a 3-cycle low glitch -> still no pulse.
- Auto-repeat: key_n[3] held low for 60 cycles ->
  - inc_addr rises 7 cycles after press and stays high 20 cycles.
  - It then toggles 4 low / 4 high.
  - Count the rising edges (1 initial + repeats, per the timing).
  - inc_addr = 0 within 7 cycles of release.
- Priority: dec held, then inc pressed while dec is repeating ->
  - dec_addr drops to 0 and inc_addr rises, both on the cycle key_pressed[3] rises.
  - Inc is released while dec stays held -> dec_addr stays 0.
- Simultaneous read/write: key_n=4'b1100 pressed together -> one read pulse, no write pulse.
- Async reset mid-repeat: assert reset_n=0 asynchronously while inc_addr=1 -> all outputs 0 before the next clk edge. After reset is released with the key still held, inc_addr rises only after 7 cycles.

Source files
------------

// File: rtl/key_command_conditioner.sv
// Key command conditioner: turns the four raw, active-low, bouncing KEY
// pushbuttons into clean commands for the SDRAM read/write master.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   key_n[3:0]   raw KEY pins, 0 = pressed; [3]=inc, [2]=dec, [1]=read, [0]=write
//   inc_addr     address-increment level with auto-repeat edges
//   dec_addr     address-decrement level with auto-repeat edges
//   read         one-cycle read request pulse
//   write        one-cycle write request pulse
//   key_pressed  debounced pressed state (1 = pressed), debug
//
// Per key: 2-flop synchroniser -> stable-count debouncer -> either a one-shot
// pulse (read/write) or a repeat FSM (inc/dec). All outputs are registered.
module key_command_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic       inc_addr,
  output logic       dec_addr,
  output logic       read,
  output logic       write,
  output logic [3:0] key_pressed
);

  localparam int unsigned N_KEYS = 4;
  localparam int unsigned N_RPT  = 2;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(REPEAT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_HOLD = 2'd1,
    R_LO   = 2'd2,
    R_HI   = 2'd3
  } rpt_state_t;

  logic [N_KEYS-1:0] sync_q1;
  logic [N_KEYS-1:0] sync_q2;
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  db_cnt [N_KEYS];

  logic [N_KEYS-1:0] pressed;
  logic [N_KEYS-1:0] rise;

  rpt_state_t        rpt_state     [N_RPT];
  rpt_state_t        rpt_state_nxt [N_RPT];
  logic [CNT_W-1:0]  rpt_cnt       [N_RPT];
  logic [CNT_W-1:0]  rpt_cnt_nxt   [N_RPT];
  logic [N_RPT-1:0]  rpt_level_nxt;
  logic [N_RPT-1:0]  rpt_start;
  logic [N_RPT-1:0]  rpt_allow;

  // Two-flop synchroniser; released (1) out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the current stable level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '1;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_KEYS); i++) begin
        if (sync_q2[i] != stable[i]) begin
          if (db_cnt[i] >= DB_LAST) begin
            stable[i] <= sync_q2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_ONE;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // key_pressed doubles as the previous-cycle pressed state for edge detection.
  assign pressed = ~stable;
  assign rise    = pressed & ~key_pressed;

  // Channel 0 = inc (key 3), channel 1 = dec (key 2). Dec is forced idle while
  // inc is pressed and only restarts on a fresh dec press edge.
  assign rpt_start = {rise[2], rise[3]};
  assign rpt_allow = {pressed[2] & ~pressed[3], pressed[3]};

  // Repeat FSM next-state and counter logic for both channels.
  always_comb begin
    for (int c = 0; c < int'(N_RPT); c++) begin
      rpt_state_nxt[c] = rpt_state[c];
      rpt_cnt_nxt[c]   = rpt_cnt[c];
      rpt_level_nxt[c] = 1'b0;

      if (!rpt_allow[c]) begin
        rpt_state_nxt[c] = R_IDLE;
        rpt_cnt_nxt[c]   = '0;
      end else begin
        case (rpt_state[c])
          R_IDLE: begin
            if (rpt_start[c]) begin
              rpt_state_nxt[c] = R_HOLD;
              rpt_cnt_nxt[c]   = '0;
            end
          end
          R_HOLD: begin
            // Without repeat the counter parks at RD_LAST instead of wrapping.
            if (rpt_cnt[c] >= RD_LAST) begin
              if (REPEAT_EN) begin
                rpt_state_nxt[c] = R_LO;
                rpt_cnt_nxt[c]   = '0;
              end
            end else begin
              rpt_cnt_nxt[c] = rpt_cnt[c] + CNT_ONE;
            end
          end
          R_LO: begin
            if (rpt_cnt[c] >= HALF_LAST) begin
              rpt_state_nxt[c] = R_HI;
              rpt_cnt_nxt[c]   = '0;
            end else begin
              rpt_cnt_nxt[c] = rpt_cnt[c] + CNT_ONE;
            end
          end
          R_HI: begin
            if (rpt_cnt[c] >= HALF_LAST) begin
              rpt_state_nxt[c] = R_LO;
              rpt_cnt_nxt[c]   = '0;
            end else begin
              rpt_cnt_nxt[c] = rpt_cnt[c] + CNT_ONE;
            end
          end
          default: begin
            rpt_state_nxt[c] = R_IDLE;
            rpt_cnt_nxt[c]   = '0;
          end
        endcase
      end

      rpt_level_nxt[c] = (rpt_state_nxt[c] == R_HOLD) || (rpt_state_nxt[c] == R_HI);
    end
  end

  // Repeat FSM state, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < int'(N_RPT); c++) begin
        rpt_state[c] <= R_IDLE;
        rpt_cnt[c]   <= '0;
      end
      key_pressed <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      inc_addr    <= 1'b0;
      dec_addr    <= 1'b0;
    end else begin
      for (int c = 0; c < int'(N_RPT); c++) begin
        rpt_state[c] <= rpt_state_nxt[c];
        rpt_cnt[c]   <= rpt_cnt_nxt[c];
      end
      key_pressed <= pressed;
      // Read wins when both press edges land in the same cycle.
      read        <= rise[1];
      write       <= rise[0] & ~rise[1];
      inc_addr    <= rpt_level_nxt[0];
      dec_addr    <= rpt_level_nxt[1];
    end
  end

endmodule
